// File: rtl/req_encoder_4x2.sv
// Sequential 4-to-2 request encoder: rising edges on req become sticky pending
// flags, one of which is encoded per cycle onto a valid/ready output register.
// Define REQ_ENCODER_ROUND_ROBIN_EN for round-robin selection (fixed 3>2>1>0 otherwise).
module req_encoder_4x2 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [1:0]       out_idx,
  output logic [3:0]       pending,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam int               SUM_W   = CNT_W + 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [3:0]       req_q;
  logic [3:0]       pending_q, pending_d;
  logic [1:0]       out_idx_q, out_idx_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [3:0]       rise;
  logic [3:0]       load_mask;
  logic [3:0]       drop_bits;
  logic [1:0]       sel_idx;
  logic             load;
  logic [2:0]       drop_num;
  logic [SUM_W-1:0] drop_sum;

  assign rise = req & ~req_q;
  assign load = (pending_q != 4'b0000) && ((state_q == EMPTY) || out_ready);

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;

  // Walk from the farthest offset back to ptr so the nearest pending bit wins.
  always_comb begin
    sel_idx = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (pending_q[ptr_q + 2'(k)]) begin
        sel_idx = ptr_q + 2'(k);
      end
    end
  end

  assign ptr_d = load ? (sel_idx + 2'd1) : ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    sel_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (pending_q[k]) begin
        sel_idx = 2'(k);
      end
    end
  end
`endif

  // A rise on the bit being loaded re-arms it (set wins) and is not a drop.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bit
    assign load_mask[gi] = load && (sel_idx == 2'(gi));
    assign drop_bits[gi] = rise[gi] && pending_q[gi] && !load_mask[gi];
    assign pending_d[gi] = rise[gi] || (pending_q[gi] && !load_mask[gi]);
  end

  always_comb begin
    drop_num   = 3'($countones(drop_bits));
    drop_sum   = SUM_W'(drop_cnt_q) + SUM_W'(drop_num);
    drop_cnt_d = (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
  end

  assign out_idx_d = load ? sel_idx : out_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = FULL;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    out_valid = (state_q == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= 4'b0000;
      pending_q  <= 4'b0000;
      out_idx_q  <= 2'd0;
      drop_cnt_q <= '0;
    end else begin
      req_q      <= req;
      pending_q  <= pending_d;
      out_idx_q  <= out_idx_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_idx  = out_idx_q;
  assign pending  = pending_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_req_encoder_4x2.sv
// Bench for req_encoder_4x2: directed scenarios plus a randomized run against a
// behavioural model; a CNT_W=2 instance shares the stimulus to exercise saturation.
module tb_req_encoder_4x2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       out_ready = 1'b0;

  logic       out_valid;
  logic [1:0] out_idx;
  logic [3:0] pending;
  logic [7:0] drop_cnt;

  logic       b_out_valid;
  logic [1:0] b_out_idx;
  logic [3:0] b_pending;
  logic [1:0] b_drop_cnt;

  int total = 0;
  int bad = 0;

  req_encoder_4x2 #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .out_valid(out_valid), .out_idx(out_idx), .pending(pending), .drop_cnt(drop_cnt)
  );

  req_encoder_4x2 #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .out_valid(b_out_valid), .out_idx(b_out_idx), .pending(b_pending), .drop_cnt(b_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset low mid-cycle and release on a falling edge with the given inputs.
  task automatic apply_reset(input logic [3:0] r, input logic rdy);
    rst_n = 1'b0;
    req = r;
    out_ready = rdy;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
    total++; if (out_idx !== 2'd0) begin bad++; $display("FAIL rst_idx got=%0d want=0", out_idx); end
    total++; if (pending !== 4'b0000) begin bad++; $display("FAIL rst_pending got=%b want=0000", pending); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL rst_drop got=%0d want=0", drop_cnt); end
    total++; if (b_drop_cnt !== 2'd0) begin bad++; $display("FAIL rst_drop_small got=%0d want=0", b_drop_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    req = 4'b0100;
    tick();
    total++; if (pending !== 4'b0100) begin bad++; $display("FAIL first_pending got=%b want=0100", pending); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL first_valid_early got=%b want=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || out_idx !== 2'd2) begin
      bad++; $display("FAIL first_out got=v%b/i%0d want=v1/i2", out_valid, out_idx);
    end
    total++; if (pending !== 4'b0000) begin bad++; $display("FAIL first_pending_clr got=%b want=0000", pending); end
    $display("test_reset: delivered idx=%0d", out_idx);
  endtask

  task automatic test_priority();
    int exp_seq[3];
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 3};
`else
    exp_seq = '{3, 1, 0};
`endif
    apply_reset(4'b0000, 1'b1);
    tick();
    req = 4'b1011;
    tick();
    total++; if (pending !== 4'b1011) begin bad++; $display("FAIL prio_pending got=%b want=1011", pending); end
    for (int n = 0; n < 3; n++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_idx !== 2'(exp_seq[n])) begin
        bad++; $display("FAIL prio_seq n=%0d got=v%b/i%0d want=v1/i%0d", n, out_valid, out_idx, exp_seq[n]);
      end
      $display("test_priority: n=%0d idx=%0d", n, out_idx);
    end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL prio_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_stall();
    apply_reset(4'b0000, 1'b0);
    req = 4'b1000;
    tick();
    tick();
    req = 4'b1001;
    tick();
    for (int n = 0; n < 5; n++) begin
      total++; if (out_valid !== 1'b1 || out_idx !== 2'd3 || pending !== 4'b0001) begin
        bad++; $display("FAIL stall_hold n=%0d got=v%b/i%0d/p%b want=v1/i3/p0001", n, out_valid, out_idx, pending);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || out_idx !== 2'd0 || pending !== 4'b0000) begin
      bad++; $display("FAIL stall_release got=v%b/i%0d/p%b want=v1/i0/p0000", out_valid, out_idx, pending);
    end
    $display("test_stall: released idx=%0d", out_idx);
  endtask

  task automatic test_drop();
    int n_drop;
    apply_reset(4'b0000, 1'b0);
    req = 4'b1000;
    tick();
    tick();
    req = 4'b1010;
    tick();
    n_drop = 0;
    for (int p = 0; p < 5; p++) begin
      req = 4'b1000;
      tick();
      req = 4'b1010;
      tick();
      n_drop++;
      total++; if (drop_cnt !== 8'(n_drop)) begin bad++; $display("FAIL drop_cnt p=%0d got=%0d want=%0d", p, drop_cnt, n_drop); end
      total++; if (b_drop_cnt !== 2'((n_drop > 3) ? 3 : n_drop)) begin
        bad++; $display("FAIL drop_sat p=%0d got=%0d want=%0d", p, b_drop_cnt, (n_drop > 3) ? 3 : n_drop);
      end
      total++; if (pending !== 4'b0010) begin bad++; $display("FAIL drop_pending p=%0d got=%b want=0010", p, pending); end
    end
    // Multi-bit drops in one cycle.
    req = 4'b1000;
    tick();
    req = 4'b1111;
    tick();
    total++; if (drop_cnt !== 8'd6) begin bad++; $display("FAIL drop_multi1 got=%0d want=6", drop_cnt); end
    req = 4'b1000;
    tick();
    req = 4'b1111;
    tick();
    total++; if (drop_cnt !== 8'd9 || b_drop_cnt !== 2'd3) begin
      bad++; $display("FAIL drop_multi3 got=%0d/%0d want=9/3", drop_cnt, b_drop_cnt);
    end
    total++; if (out_valid !== 1'b1 || out_idx !== 2'd3) begin
      bad++; $display("FAIL drop_out got=v%b/i%0d want=v1/i3", out_valid, out_idx);
    end
    $display("test_drop: drop_cnt=%0d small=%0d", drop_cnt, b_drop_cnt);
  endtask

  task automatic test_set_clear();
    apply_reset(4'b0000, 1'b0);
    req = 4'b1000;
    tick();
    tick();
    req = 4'b1100;
    tick();
    req = 4'b1000;
    tick();
    req = 4'b1100;
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || out_idx !== 2'd2) begin
      bad++; $display("FAIL setclr_load got=v%b/i%0d want=v1/i2", out_valid, out_idx);
    end
    total++; if (pending !== 4'b0100) begin bad++; $display("FAIL setclr_pending got=%b want=0100", pending); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL setclr_drop got=%0d want=0", drop_cnt); end
    tick();
    total++; if (out_valid !== 1'b1 || out_idx !== 2'd2 || pending !== 4'b0000) begin
      bad++; $display("FAIL setclr_second got=v%b/i%0d/p%b want=v1/i2/p0000", out_valid, out_idx, pending);
    end
    $display("test_set_clear: second idx=%0d", out_idx);
  endtask

  task automatic test_reset_mid();
    apply_reset(4'b0000, 1'b0);
    req = 4'b1000;
    tick();
    tick();
    req = 4'b1110;
    tick();
    total++; if (out_valid !== 1'b1 || pending !== 4'b0110) begin
      bad++; $display("FAIL mid_pre got=v%b/p%b want=v1/p0110", out_valid, pending);
    end
    req = 4'b0001;
    out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_idx !== 2'd0 || pending !== 4'b0000 || drop_cnt !== 8'd0) begin
      bad++; $display("FAIL mid_async got=v%b/i%0d/p%b/d%0d want=all0", out_valid, out_idx, pending, drop_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || pending !== 4'b0001) begin
      bad++; $display("FAIL mid_edge1 got=v%b/p%b want=v0/p0001", out_valid, pending);
    end
    tick();
    total++; if (out_valid !== 1'b1 || out_idx !== 2'd0) begin
      bad++; $display("FAIL mid_edge2 got=v%b/i%0d want=v1/i0", out_valid, out_idx);
    end
    $display("test_reset_mid: idx=%0d after release", out_idx);
  endtask

  task automatic test_random();
    bit [3:0] m_req_q, m_pend, rise, cur_req;
    bit       m_valid, cur_rdy, load, found;
    int       m_idx, m_ptr, m_drops, g, idx, exp8, exp2;
    apply_reset(4'b0000, 1'b0);
    m_req_q = '0; m_pend = '0; m_valid = 1'b0; m_idx = 0; m_ptr = 0; m_drops = 0;
    for (int c = 0; c < 600; c++) begin
      cur_req = 4'($urandom);
      cur_rdy = ($urandom_range(0, 3) != 0);
      req = cur_req;
      out_ready = cur_rdy;
      tick();
      rise = cur_req & ~m_req_q;
      load = (m_pend != 0) && (!m_valid || cur_rdy);
      g = -1;
      if (load) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
          idx = (m_ptr + k) % 4;
`else
          idx = 3 - k;
`endif
          if (!found && m_pend[idx]) begin
            g = idx;
            found = 1'b1;
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (rise[i] && m_pend[i] && i != g) m_drops++;
        if (i == g) m_pend[i] = 1'b0;
        if (rise[i]) m_pend[i] = 1'b1;
      end
      if (load) begin
        m_valid = 1'b1;
        m_idx = g;
        m_ptr = (g + 1) % 4;
      end else if (m_valid && cur_rdy) begin
        m_valid = 1'b0;
      end
      m_req_q = cur_req;
      exp8 = (m_drops > 255) ? 255 : m_drops;
      exp2 = (m_drops > 3) ? 3 : m_drops;
      total++; if (out_valid !== m_valid || (m_valid && out_idx !== 2'(m_idx))) begin
        bad++; $display("FAIL rand_out c=%0d got=v%b/i%0d want=v%b/i%0d", c, out_valid, out_idx, m_valid, m_idx);
      end
      total++; if (pending !== m_pend) begin bad++; $display("FAIL rand_pending c=%0d got=%b want=%b", c, pending, m_pend); end
      total++; if (drop_cnt !== 8'(exp8) || b_drop_cnt !== 2'(exp2)) begin
        bad++; $display("FAIL rand_drop c=%0d got=%0d/%0d want=%0d/%0d", c, drop_cnt, b_drop_cnt, exp8, exp2);
      end
      total++; if (b_out_valid !== out_valid || b_pending !== pending || (out_valid && b_out_idx !== out_idx)) begin
        bad++; $display("FAIL rand_small c=%0d got=v%b/i%0d/p%b want=v%b/i%0d/p%b", c, b_out_valid, b_out_idx, b_pending, m_valid, m_idx, m_pend);
      end
    end
    $display("test_random: 600 cycles, model drops=%0d", m_drops);
  endtask

  initial begin
    test_reset();
    test_priority();
    test_stall();
    test_drop();
    test_set_clear();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
